// File: rtl/bullet_pkg.sv
// bullet_pkg: shared colour codes, empty-pattern index and pattern record layout for the bullet generator
package bullet_pkg;
  localparam logic [2:0] COL_WHITE     = 3'b000;
  localparam logic [2:0] COL_GREEN     = 3'b001;
  localparam logic [2:0] COL_BLUE      = 3'b010;
  localparam logic [2:0] PATTERN_EMPTY = 3'd7;
  typedef struct packed {
    logic [7:0]        x;
    logic [7:0]        y;
    logic [7:0]        w;
    logic [7:0]        h;
    logic signed [7:0] vx;
    logic signed [7:0] vy;
    logic [2:0]        col;
  } pattern_t;
endpackage

// File: rtl/bullet_pattern_rom.sv
// bullet_pattern_rom: combinational pattern ROM; idx_i pattern index in, pat_o start/size/velocity/colour record out
module bullet_pattern_rom
  import bullet_pkg::*;
(
  input  logic [2:0] idx_i,
  output pattern_t   pat_o
);
  always_comb begin
    case (idx_i)
      3'd0:    pat_o = '{x: 8'd0,   y: 8'd100, w: 8'd8,  h: 8'd8,  vx: 8'sd1,  vy: 8'sd0, col: COL_WHITE};
      3'd1:    pat_o = '{x: 8'd100, y: 8'd0,   w: 8'd8,  h: 8'd8,  vx: 8'sd0,  vy: 8'sd1, col: COL_BLUE};
      3'd2:    pat_o = '{x: 8'd200, y: 8'd100, w: 8'd8,  h: 8'd8,  vx: -8'sd1, vy: 8'sd0, col: COL_GREEN};
      3'd3:    pat_o = '{x: 8'd0,   y: 8'd0,   w: 8'd4,  h: 8'd4,  vx: 8'sd1,  vy: 8'sd1, col: COL_WHITE};
      3'd4:    pat_o = '{x: 8'd0,   y: 8'd60,  w: 8'd16, h: 8'd4,  vx: 8'sd2,  vy: 8'sd0, col: COL_WHITE};
      3'd5:    pat_o = '{x: 8'd60,  y: 8'd0,   w: 8'd4,  h: 8'd16, vx: 8'sd0,  vy: 8'sd2, col: COL_BLUE};
      3'd6:    pat_o = '{x: 8'd200, y: 8'd60,  w: 8'd16, h: 8'd4,  vx: -8'sd2, vy: 8'sd0, col: COL_GREEN};
      default: pat_o = '0;
    endcase
  end
endmodule

// File: rtl/bullet.sv
// bullet: two-slot bullet generator; index1/2, isRun, isCollide in; per-slot position, size, color, isRender out (registered)
module bullet
  import bullet_pkg::*;
#(
  parameter int         TICK_DIV      = 1,
  parameter logic [7:0] ARENA_MAX     = 8'd239,
  parameter int         RESPAWN_TICKS = 4
) (
  output logic [15:0] position1,
  output logic [15:0] size1,
  output logic [2:0]  color1,
  output logic        isRender1,
  output logic [15:0] position2,
  output logic [15:0] size2,
  output logic [2:0]  color2,
  output logic        isRender2,
  input  logic [2:0]  index1,
  input  logic [2:0]  index2,
  input  logic        isRun,
  input  logic        clk,
  input  logic        isCollide,
  input  logic        rst_n
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(RESPAWN_TICKS + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic tick;
  logic [1:0][15:0] pos, sz;
  logic [1:0][2:0] col, idx_in;
  logic [1:0] ren;
  assign tick   = isRun && tcnt_q == TW'(TICK_DIV - 1);
  assign tcnt_d = !isRun ? tcnt_q : tick ? '0 : tcnt_q + TW'(1);
  assign idx_in = {index2, index1};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '0;
    else tcnt_q <= tcnt_d;
  end
  for (genvar s = 0; s < 2; s++) begin : g_slot
    pattern_t pat;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic [15:0] sz_q, sz_d;
    logic [2:0] col_q, col_d, idx_q, idx_d;
    logic ld_q, ld_d, vis_q, vis_d;
    logic [HW-1:0] hide_q, hide_d;
    logic load, hit;
    logic [8:0] nx, ny;
    assign load = !ld_q || idx_in[s] != idx_q;
    // a slot still counting down is re-hit too, so a held isCollide keeps it hidden
    assign hit  = isCollide && (vis_q || hide_q != '0);
    bullet_pattern_rom u_rom (.idx_i(load ? idx_in[s] : idx_q), .pat_o(pat));
    assign nx = {1'b0, x_q} + {pat.vx[7], pat.vx};
    assign ny = {1'b0, y_q} + {pat.vy[7], pat.vy};
    always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      sz_d   = sz_q;
      col_d  = col_q;
      idx_d  = idx_q;
      ld_d   = ld_q;
      vis_d  = vis_q;
      hide_d = hide_q;
      if (load) begin
        x_d    = pat.x;
        y_d    = pat.y;
        sz_d   = {pat.w, pat.h};
        col_d  = pat.col;
        idx_d  = idx_in[s];
        ld_d   = 1'b1;
        vis_d  = idx_in[s] != PATTERN_EMPTY;
        hide_d = '0;
      end else if (hit) begin
        x_d    = pat.x;
        y_d    = pat.y;
        vis_d  = RESPAWN_TICKS == 0;
        hide_d = HW'(RESPAWN_TICKS);
      end else if (hide_q != '0) begin
        if (tick) begin
          hide_d = hide_q - HW'(1);
          vis_d  = hide_q == HW'(1);
        end
      end else if (tick && vis_q) begin
        // bit 8 set (wrap below 0 or past 255) also exceeds ARENA_MAX
        x_d = (nx > {1'b0, ARENA_MAX} || ny > {1'b0, ARENA_MAX}) ? pat.x : nx[7:0];
        y_d = (nx > {1'b0, ARENA_MAX} || ny > {1'b0, ARENA_MAX}) ? pat.y : ny[7:0];
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q    <= '0;
        y_q    <= '0;
        sz_q   <= '0;
        col_q  <= '0;
        idx_q  <= '0;
        ld_q   <= 1'b0;
        vis_q  <= 1'b0;
        hide_q <= '0;
      end else begin
        x_q    <= x_d;
        y_q    <= y_d;
        sz_q   <= sz_d;
        col_q  <= col_d;
        idx_q  <= idx_d;
        ld_q   <= ld_d;
        vis_q  <= vis_d;
        hide_q <= hide_d;
      end
    end
    assign pos[s] = {x_q, y_q};
    assign sz[s]  = sz_q;
    assign col[s] = col_q;
    assign ren[s] = vis_q;
  end
  assign position1 = pos[0];
  assign size1     = sz[0];
  assign color1    = col[0];
  assign isRender1 = ren[0];
  assign position2 = pos[1];
  assign size2     = sz[1];
  assign color2    = col[1];
  assign isRender2 = ren[1];
endmodule

// File: tb/tb_bullet.sv
// tb_bullet: scoreboard bench for bullet; directed stimulus pushes expected outputs, a negedge monitor pops and compares
module tb_bullet;
  logic [15:0] position1, size1, position2, size2;
  logic [2:0] color1, color2, index1, index2;
  logic isRender1, isRender2, isRun, isCollide, rst_n;
  logic clk = 1'b0;
  typedef struct {
    string      nm;
    logic [69:0] v;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  event chk_ev;
  always #5 clk = ~clk;
  bullet dut (
    .position1(position1), .size1(size1), .color1(color1), .isRender1(isRender1),
    .position2(position2), .size2(size2), .color2(color2), .isRender2(isRender2),
    .index1(index1), .index2(index2), .isRun(isRun), .clk(clk),
    .isCollide(isCollide), .rst_n(rst_n)
  );
  function automatic logic [15:0] sz(input logic [2:0] p);
    case (p)
      3'd0, 3'd1, 3'd2: return 16'h0808;
      3'd3:             return 16'h0404;
      3'd4, 3'd6:       return 16'h1004;
      3'd5:             return 16'h0410;
      default:          return 16'h0000;
    endcase
  endfunction
  function automatic logic [2:0] co(input logic [2:0] p);
    case (p)
      3'd1, 3'd5: return 3'b010;
      3'd2, 3'd6: return 3'b001;
      default:    return 3'b000;
    endcase
  endfunction
  initial forever begin
    exp_t e;
    logic [69:0] act;
    @(negedge clk or chk_ev);
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {position1, size1, color1, isRender1, position2, size2, color2, isRender2};
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL %s: got p1=%h s1=%h c1=%b r1=%b p2=%h s2=%h c2=%b r2=%b, expected p1=%h s1=%h c1=%b r1=%b p2=%h s2=%h c2=%b r2=%b",
                 e.nm, act[69:54], act[53:38], act[37:35], act[34], act[33:18], act[17:2], act[1:0] >> 1, act[0],
                 e.v[69:54], e.v[53:38], e.v[37:35], e.v[34], e.v[33:18], e.v[17:2], e.v[1:0] >> 1, e.v[0]);
      end
    end
  end
  task automatic push(input string nm, input logic [15:0] p1, input logic r1, input logic [2:0] e1,
                      input logic [15:0] p2, input logic r2, input logic [2:0] e2);
    exp_t e;
    e.nm = nm;
    e.v  = {p1, sz(e1), co(e1), r1, p2, sz(e2), co(e2), r2};
    q.push_back(e);
  endtask
  task automatic step(input string nm, input logic [2:0] i1, input logic [2:0] i2, input logic run, input logic cl,
                      input logic [15:0] p1, input logic r1, input logic [2:0] e1,
                      input logic [15:0] p2, input logic r2, input logic [2:0] e2);
    index1 = i1;
    index2 = i2;
    isRun = run;
    isCollide = cl;
    push(nm, p1, r1, e1, p2, r2, e2);
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    step("reset", 0, 0, 1, 0, 16'h0000, 0, 7, 16'h0000, 0, 7);
    rst_n = 1'b1;
    step("load", 0, 0, 1, 0, 16'h0064, 1, 0, 16'h0064, 1, 0);
    step("mv1", 0, 0, 1, 0, 16'h0164, 1, 0, 16'h0164, 1, 0);
    step("mv2", 0, 0, 1, 0, 16'h0264, 1, 0, 16'h0264, 1, 0);
    step("mv3", 0, 0, 1, 0, 16'h0364, 1, 0, 16'h0364, 1, 0);
    step("collide", 0, 0, 1, 1, 16'h0064, 0, 0, 16'h0064, 0, 0);
    step("hide3", 0, 0, 1, 0, 16'h0064, 0, 0, 16'h0064, 0, 0);
    step("hide2", 0, 0, 1, 0, 16'h0064, 0, 0, 16'h0064, 0, 0);
    step("hide1", 0, 0, 1, 0, 16'h0064, 0, 0, 16'h0064, 0, 0);
    step("reappear", 0, 0, 1, 0, 16'h0064, 1, 0, 16'h0064, 1, 0);
    step("resume", 0, 0, 1, 0, 16'h0164, 1, 0, 16'h0164, 1, 0);
    step("idx0to1", 1, 0, 1, 0, 16'h6400, 1, 1, 16'h0264, 1, 0);
    step("ymove", 1, 0, 1, 0, 16'h6401, 1, 1, 16'h0364, 1, 0);
    step("ld0and2", 0, 2, 1, 0, 16'h0064, 1, 0, 16'hC864, 1, 2);
    for (int k = 1; k <= 241; k++) begin
      logic [7:0] x1, x2;
      x1 = 8'((k <= 239) ? k : k - 240);
      x2 = 8'((k <= 200) ? 200 - k : 401 - k);
      step($sformatf("sweep%0d", k), 0, 2, 1, 0, {x1, 8'd100}, 1, 0, {x2, 8'd100}, 1, 2);
    end
    step("collide2", 0, 2, 1, 1, 16'h0064, 0, 0, 16'hC864, 0, 2);
    step("tick3", 0, 2, 1, 0, 16'h0064, 0, 0, 16'hC864, 0, 2);
    for (int k = 0; k < 10; k++)
      step($sformatf("paused%0d", k), 0, 2, 0, 0, 16'h0064, 0, 0, 16'hC864, 0, 2);
    step("idx7stop", 0, 7, 0, 0, 16'h0064, 0, 0, 16'h0000, 0, 7);
    step("tick2", 0, 7, 1, 0, 16'h0064, 0, 0, 16'h0000, 0, 7);
    step("tick1", 0, 7, 1, 0, 16'h0064, 0, 0, 16'h0000, 0, 7);
    step("tick0", 0, 7, 1, 0, 16'h0064, 1, 0, 16'h0000, 0, 7);
    step("mvafter", 0, 7, 1, 0, 16'h0164, 1, 0, 16'h0000, 0, 7);
    step("frozen1", 0, 7, 0, 0, 16'h0164, 1, 0, 16'h0000, 0, 7);
    step("frozen2", 0, 7, 0, 0, 16'h0164, 1, 0, 16'h0000, 0, 7);
    step("hold1", 0, 7, 1, 1, 16'h0064, 0, 0, 16'h0000, 0, 7);
    step("hold2", 0, 7, 1, 1, 16'h0064, 0, 0, 16'h0000, 0, 7);
    step("hold3", 0, 7, 1, 1, 16'h0064, 0, 0, 16'h0000, 0, 7);
    step("rel3", 0, 7, 1, 0, 16'h0064, 0, 0, 16'h0000, 0, 7);
    step("rel2", 0, 7, 1, 0, 16'h0064, 0, 0, 16'h0000, 0, 7);
    step("rel1", 0, 7, 1, 0, 16'h0064, 0, 0, 16'h0000, 0, 7);
    step("rel0", 0, 7, 1, 0, 16'h0064, 1, 0, 16'h0000, 0, 7);
    step("mvrel1", 0, 7, 1, 0, 16'h0164, 1, 0, 16'h0000, 0, 7);
    step("mvrel2", 0, 7, 1, 0, 16'h0264, 1, 0, 16'h0000, 0, 7);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    push("async_rst", 16'h0000, 0, 7, 16'h0000, 0, 7);
    -> chk_ev;
    #1;
    step("rst_held", 0, 7, 1, 0, 16'h0000, 0, 7, 16'h0000, 0, 7);
    rst_n = 1'b1;
    step("reload", 0, 7, 1, 0, 16'h0064, 1, 0, 16'h0000, 0, 7);
    step("mvreload", 0, 7, 1, 0, 16'h0164, 1, 0, 16'h0000, 0, 7);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
